// File: rtl/seq_chain_sched.sv
// Round-robin scheduler that lends an external serial delay chain to one of two
// requesters at a time, loops a word through it and returns the result.
module seq_chain_sched #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             chain_d,
  output logic             chain_clr,
  input  logic             chain_q,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);

  localparam int TOTAL = WIDTH + DEPTH;
  localparam int TCW   = $clog2(TOTAL + 1);
  localparam logic [TCW-1:0] TC_LAST = TCW'(TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SHIFT,
    RESP
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [TCW-1:0]   tc;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] cap_next;
  logic             id;
  logic             last_gnt;
  logic             win_id;
  logic             tx_bit;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    win_id = (req == 2'b11) ? ~last_gnt : req[1];
  end

  // Bit k leaves in SHIFT cycle k and returns DEPTH cycles later, so both the
  // transmit select and the capture slot are pure functions of tc.
  always_comb begin
    tx_bit   = 1'b0;
    cap_next = cap;
    for (int i = 0; i < WIDTH; i++) begin
      if (tc == TCW'(i)) begin
        tx_bit = word[i];
      end
      if (tc == TCW'(i + DEPTH)) begin
        cap_next[i] = chain_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    gnt        = 2'b00;
    busy       = 1'b0;
    chain_d    = 1'b0;
    chain_clr  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        gnt        = id ? 2'b10 : 2'b01;
        chain_clr  = 1'b1;
        busy       = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        busy    = 1'b1;
        chain_d = tx_bit;
        if (tc == TC_LAST) begin
          state_next = RESP;
        end
      end
      RESP: begin
        busy       = 1'b1;
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The response registers load on the final SHIFT edge so they only change
  // as the block enters RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tc       <= '0;
      word     <= '0;
      cap      <= '0;
      id       <= 1'b0;
      last_gnt <= 1'b1;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            word     <= win_id ? wdata1 : wdata0;
            id       <= win_id;
            last_gnt <= win_id;
          end
        end
        CLEAR: begin
          tc  <= '0;
          cap <= '0;
        end
        SHIFT: begin
          tc  <= tc + TCW'(1);
          cap <= cap_next;
          if (tc == TC_LAST) begin
            rsp_data <= cap_next;
            rsp_err  <= (cap_next != word);
            rsp_id   <= id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chain_sched.sv
// Bench for seq_chain_sched: behavioural chains, directed transactions and a
// randomized two-requester run checked against a timeline model.
module tb_seq_chain_sched;

  localparam int MW = 8;
  localparam int MD = 8;
  localparam int SW = 4;
  localparam int SD = 2;
  localparam int LAT = MW + MD + 2;

  logic clk;
  logic reset;
  logic fault;

  logic [1:0]    req;
  logic [MW-1:0] wdata0, wdata1;
  logic [1:0]    gnt;
  logic          busy, chain_d, chain_clr, chain_q, rsp_valid, rsp_id, rsp_err;
  logic [MW-1:0] rsp_data;
  logic [MD-1:0] chain_m;

  logic [1:0]    s_req;
  logic [SW-1:0] s_wdata0, s_wdata1;
  logic [1:0]    s_gnt;
  logic          s_busy, s_chain_d, s_chain_clr, s_chain_q, s_rsp_valid, s_rsp_id, s_rsp_err;
  logic [SW-1:0] s_rsp_data;
  logic [SD-1:0] s_chain_m;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic last;

  seq_chain_sched #(.WIDTH(MW), .DEPTH(MD)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .busy(busy), .chain_d(chain_d), .chain_clr(chain_clr),
    .chain_q(chain_q), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  seq_chain_sched #(.WIDTH(SW), .DEPTH(SD)) dut_s (
    .clk(clk), .reset(reset), .req(s_req), .wdata0(s_wdata0), .wdata1(s_wdata1),
    .gnt(s_gnt), .busy(s_busy), .chain_d(s_chain_d), .chain_clr(s_chain_clr),
    .chain_q(s_chain_q), .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id),
    .rsp_data(s_rsp_data), .rsp_err(s_rsp_err)
  );

  // Plain shift-register chains without reset; fault forces the main output low.
  always @(posedge clk) begin
    chain_m   <= chain_clr ? '0 : {chain_m[MD-2:0], chain_d};
    s_chain_m <= s_chain_clr ? '0 : {s_chain_m[SD-2:0], s_chain_d};
  end
  assign chain_q   = fault ? 1'b0 : chain_m[MD-1];
  assign s_chain_q = s_chain_m[SD-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = 2'b00;
    s_req = 2'b00;
    repeat (3) step();
    reset = 1'b1;
    last  = 1'b1;
    step();
  endtask

  // Called in an IDLE cycle; returns in the IDLE cycle right after RESP.
  task automatic txn(input logic [1:0] rv, input logic [MW-1:0] d0, input logic [MW-1:0] d1,
                     input int late_at, input string tag);
    logic          win;
    logic [MW-1:0] w, exp_data;
    logic          ok;
    win      = (rv == 2'b11) ? ~last : rv[1];
    last     = win;
    w        = win ? d1 : d0;
    exp_data = fault ? '0 : w;
    req      = rv;
    wdata0   = d0;
    wdata1   = d1;
    step();
    check({tag, "_gnt"}, 32'(gnt), win ? 32'h2 : 32'h1);
    check({tag, "_clr"}, 32'({chain_clr, busy}), 32'h3);
    req[win] = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < MW + MD; i++) begin
      step();
      if (i == late_at) req[1] = 1'b1;
      if (rsp_valid || gnt != 2'b00 || !busy) ok = 1'b0;
    end
    check({tag, "_quiet"}, 32'(ok), 32'h1);
    step();
    check({tag, "_valid"}, 32'(rsp_valid), 32'h1);
    check({tag, "_resp"}, 32'({rsp_err, rsp_id, rsp_data}),
          32'({exp_data != w, win, exp_data}));
    step();
    check({tag, "_idle"}, 32'({rsp_valid, busy, rsp_data}), 32'({2'b00, exp_data}));
  endtask

  task automatic txn_small(input logic sid, input logic [SW-1:0] w);
    logic ok;
    s_req    = sid ? 2'b10 : 2'b01;
    s_wdata0 = sid ? '0 : w;
    s_wdata1 = sid ? w : '0;
    step();
    check("s_gnt", 32'(s_gnt), sid ? 32'h2 : 32'h1);
    s_req = 2'b00;
    ok = 1'b1;
    for (int i = 0; i < SW + SD; i++) begin
      step();
      if (s_rsp_valid) ok = 1'b0;
    end
    check("s_quiet", 32'(ok), 32'h1);
    step();
    check("s_resp", 32'({s_rsp_valid, s_rsp_err, s_rsp_id, s_rsp_data}),
          32'({2'b10, sid, w}));
    step();
  endtask

  initial begin
    int            gnt_at, rsp_at, idle_at, nrsp;
    logic          gid, ok;
    logic [MW-1:0] gword;
    logic [1:0]    exp_g;

    reset = 1'b0; fault = 1'b0; req = 2'b00; wdata0 = '0; wdata1 = '0;
    s_req = 2'b00; s_wdata0 = '0; s_wdata1 = '0; last = 1'b1;
    step();
    check("reset_ctrl", 32'({gnt, busy, chain_d, chain_clr, rsp_valid}), 32'h0);
    check("reset_rsp", 32'({rsp_id, rsp_err, rsp_data}), 32'h0);
    reset = 1'b1;
    step();

    txn(2'b01, 8'hA5, 8'h00, -1, "single");

    do_reset();
    txn(2'b11, 8'h3C, 8'hC3, -1, "cont0");
    txn(2'b10, 8'h3C, 8'hC3, -1, "cont1");

    txn(2'b01, 8'h11, 8'h22, 4, "busy0");
    txn(2'b10, 8'h11, 8'h22, -1, "busy1");

    fault = 1'b1;
    txn(2'b10, 8'h00, 8'hFF, -1, "fault");
    fault = 1'b0;

    // Abort a transaction at tc=5; the chain keeps stale bits across reset.
    req = 2'b01; wdata0 = 8'h3C;
    step();
    req = 2'b00;
    repeat (6) step();
    #2 reset = 1'b0;
    #1;
    check("abort_async", 32'({gnt, busy, chain_d, chain_clr, rsp_valid, rsp_id, rsp_err, rsp_data}), 32'h0);
    ok = 1'b1;
    repeat (3) begin
      step();
      if (rsp_valid || gnt != 2'b00) ok = 1'b0;
    end
    check("abort_quiet", 32'(ok), 32'h1);
    reset = 1'b1;
    last  = 1'b1;
    step();
    txn(2'b01, 8'h5A, 8'h00, -1, "after_abort");

    // Randomized requesters against a timeline model of the arbiter.
    gnt_at = -1; rsp_at = -1; idle_at = 0; nrsp = 0; gid = 1'b0; gword = '0;
    for (int n = 0; n < 2500; n++) begin
      exp_g = (n == gnt_at) ? (gid ? 2'b10 : 2'b01) : 2'b00;
      check("rand_ctrl", 32'({gnt, rsp_valid, busy}),
            32'({exp_g, n == rsp_at, n >= gnt_at && n < idle_at}));
      if (n == rsp_at) begin
        check("rand_resp", 32'({rsp_err, rsp_id, rsp_data}), 32'({1'b0, gid, gword}));
        nrsp++;
      end
      for (int i = 0; i < 2; i++) begin
        if (req[i] && gnt[i]) req[i] = 1'b0;
        else if (req[i] && $urandom_range(0, 31) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 7) == 0) begin
          req[i] = 1'b1;
          if (i == 0) wdata0 = MW'($urandom);
          else        wdata1 = MW'($urandom);
        end
      end
      if (n >= idle_at && req != 2'b00) begin
        gid     = (req == 2'b11) ? ~last : req[1];
        last    = gid;
        gword   = gid ? wdata1 : wdata0;
        gnt_at  = n + 1;
        rsp_at  = n + LAT;
        idle_at = n + LAT + 1;
      end
      step();
    end
    check("rand_activity", 32'(nrsp > 20), 32'h1);
    req = 2'b00;

    txn_small(1'b0, 4'h9);
    for (int k = 0; k < 6; k++) txn_small(k[0], SW'($urandom));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seq_chain_sched.md
Name: seq_chain_sched

Overview:
- Round-robin scheduler that shares one serial flop delay chain between two requesters.
- The chain is the shared resource: DEPTH single-bit stages, shifting every clock, with a synchronous clear input and the last stage as output.
- Per transaction, the block grants one requester, flushes the chain, and serialises that requester's WIDTH-bit word into it LSB-first.
- It captures the delayed bitstream from the chain output, then returns the reassembled word with an integrity flag. Typical uses are loopback self-test and fixed-latency transport.

Parameters:
- WIDTH, 8, payload bits per transaction (>=1).
- DEPTH, 8, stages in the attached chain (>=1); must match the chain instance.

Ports:
- clk  input  1  rising-edge clock for the block and the chain.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- req  input  2  per-requester level request; the requester holds it until its gnt bit pulses.
- wdata0  input  WIDTH  payload of requester 0; sampled on the IDLE edge that grants it.
- wdata1  input  WIDTH  payload of requester 1; sampled on the IDLE edge that grants it.
- gnt  output  2  one-hot, one-cycle grant pulse.
- busy  output  1  high while a transaction is in progress (CLEAR, SHIFT, RESP).
- chain_d  output  1  serial data into chain stage 0.
- chain_clr  output  1  synchronous clear to every chain stage.
- chain_q  input  1  output of the last chain stage (combinational from that stage's flop).
- rsp_valid  output  1  one-cycle response strobe.
- rsp_id  output  1  requester index of the response.
- rsp_data  output  WIDTH  reassembled word; held until the next rsp_valid.
- rsp_err  output  1  1 when rsp_data differs from the transmitted word; qualified by rsp_valid, held with rsp_data.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; internal last_gnt goes to 1.
  - All outputs go to 0: gnt, busy, chain_d, chain_clr, rsp_valid, rsp_id, rsp_data, rsp_err.
  - Chain contents are don't-care; every transaction begins with a clear.
- IDLE (cycle T, any req bit set):
  - If only one req bit is set, that requester wins.
  - If both are set, the requester other than last_gnt wins.
  - On the edge ending cycle T: latch the winner's wdata and id, update last_gnt, go to CLEAR.
  - With no request, stay in IDLE; busy=0.
- CLEAR (cycle T+1):
  - gnt[id]=1, chain_clr=1, chain_d=0, busy=1.
  - Go to SHIFT with tc=0.
- SHIFT (cycles T+2 .. T+1+WIDTH+DEPTH, tc = 0 .. WIDTH+DEPTH-1):
  - chain_d = word[tc] when tc < WIDTH, else 0.
  - When tc >= DEPTH, capture chain_q into rsp_data[tc-DEPTH]. A bit driven in SHIFT cycle k appears on chain_q in cycle k+DEPTH.
  - At tc = WIDTH+DEPTH-1, go to RESP.
  - tc register width is clog2(WIDTH+DEPTH+1).
- RESP (cycle T+2+WIDTH+DEPTH):
  - rsp_valid=1, rsp_id=latched id, rsp_err = (captured != latched word).
  - Return to IDLE.
- Timing:
  - Latency from the granting IDLE edge to rsp_valid is WIDTH+DEPTH+2 cycles; with defaults, rsp_valid is at T+18.
  - Back-to-back throughput is one transaction per WIDTH+DEPTH+3 cycles.
- Boundary conditions:
  - Requests arriving while busy are not sampled; they stay pending.
  - A new req sampled in the IDLE cycle immediately after RESP is granted without an extra gap.
  - A requester that drops req before gnt is never granted.
  - gnt is never 2'b11, and no gnt occurs outside CLEAR.
  - Reset mid-transaction aborts it: no rsp_valid and no gnt; the aborted requester must re-request.
  - rsp_data/rsp_err changes only in the RESP cycle.
  - WIDTH < DEPTH and WIDTH > DEPTH must both work; for each captured bit, the capture window uses only tc.

Test Plan:
- Single request: req=01, wdata0=0xA5 at T -> gnt=01 and chain_clr=1 at T+1; rsp_valid at T+18 with rsp_data=0xA5, rsp_id=0, rsp_err=0.
- Contention: req=11 held after reset, wdata0=0x3C, wdata1=0xC3 -> gnt=01 first, gnt=10 19 cycles later; responses in order 0x3C/id0, then 0xC3/id1, both with err=0.
- Fault injection: chain_q forced to 0, wdata1=0xFF -> rsp_data=0x00, rsp_err=1, rsp_id=1.
- Reset during SHIFT at tc=5 -> all outputs 0 asynchronously, no rsp_valid. After release, req=01 with 0x5A -> rsp_data=0x5A, err=0 (CLEAR flushed stale bits).
- Request while busy: req1 rises during requester 0's SHIFT -> no gnt until after RESP; gnt=10 at RESP+2.
- Parameters WIDTH=4, DEPTH=2, wdata0=0x9 -> rsp_valid at T+8, rsp_data=0x9.
